// File: rtl/i_fetch_pkg.sv
// Shared instruction-memory definitions for the fetch stage and the instruction RAM.
package i_fetch_pkg;

    localparam int unsigned IMEM_ADDR_WIDTH = 16;
    localparam int unsigned IMEM_DATA_WIDTH = 16;
    localparam logic [IMEM_ADDR_WIDTH-1:0] IMEM_RESET_PC = 16'h0000;
    localparam int unsigned IMEM_RD_LATENCY = 1;

    // One slot per in-flight read plus one to hold a stalled head.
    localparam int unsigned SKID_DEPTH = IMEM_RD_LATENCY + 1;

endpackage

// File: rtl/i_fetch_if.sv
// Fetch-stage bus: instruction RAM read port plus the valid/ready port toward decode.
interface i_fetch_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16
) ();

    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_en;
    logic [DATA_WIDTH-1:0] imem_data;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] instr_pc;

    modport master (
        output imem_addr,
        output imem_en,
        input  imem_data,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc
    );

    modport slave (
        input  imem_addr,
        input  imem_en,
        output imem_data,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// Two-entry {pc,data} FIFO that absorbs the instruction RAM read latency.
module fetch_skid_buf
    import i_fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] push_pc,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic [1:0]            count,
    output logic [ADDR_WIDTH-1:0] head_pc,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [ADDR_WIDTH-1:0] pc_q   [SKID_DEPTH];
    logic [DATA_WIDTH-1:0] data_q [SKID_DEPTH];
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;
    logic [1:0]            count_q;
    logic                  do_push;
    logic                  do_pop;

    assign do_pop  = pop & (count_q != 2'd0);
    assign do_push = push & ((count_q != 2'(SKID_DEPTH)) | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                pc_q[i]   <= '0;
                data_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                pc_q[wr_ptr_q]   <= push_pc;
                data_q[wr_ptr_q] <= push_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    assign count     = count_q;
    assign head_pc   = pc_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];

endmodule

// File: rtl/i_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction RAM read port and
// hands {pc, instruction} to decode through a skid buffer, with redirect support.
module i_fetch
    import i_fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter int unsigned           DATA_WIDTH = IMEM_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(IMEM_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    i_fetch_if.master             bus
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic                  pending_q, pending_d;
    logic [1:0]            count;
    logic [2:0]            occupancy;
    logic                  pop;
    logic                  push;
    logic                  room;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] issue_addr;

    assign bus.instr_valid = (count != 2'd0);

    // A redirect flushes the buffer, so neither the head pop nor the arriving word counts.
    assign pop  = bus.instr_valid & bus.instr_ready & ~redirect;
    assign push = pending_q & ~redirect;

    assign occupancy  = 3'(count) + 3'(pending_q) - 3'(pop);
    assign room       = occupancy < 3'(SKID_DEPTH);
    assign issue      = rst_n & (redirect | (fetch_en & room));
    assign issue_addr = redirect ? redirect_pc : pc_q;

    assign bus.imem_en   = issue;
    assign bus.imem_addr = issue_addr;

    always_comb begin
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        pending_d = issue;
        if (issue) begin
            pend_pc_d = issue_addr;
            pc_d      = issue_addr + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            pend_pc_q <= '0;
            pending_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            pending_q <= pending_d;
        end
    end

    fetch_skid_buf #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (redirect),
        .push_pc   (pend_pc_q),
        .push_data (bus.imem_data),
        .count     (count),
        .head_pc   (bus.instr_pc),
        .head_data (bus.instr)
    );

endmodule

// File: tb/tb_i_fetch.sv
// Bench for i_fetch: two instances (RESET_PC 0x0000 and 0xFFFE) on 1-cycle RAMs with
// mem[a] = a ^ 16'hA5A5, a queue-based reference model and directed literal checks.
module tb_i_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    i_fetch_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus0 ();
    i_fetch_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus1 ();

    i_fetch #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .RESET_PC(16'h0000)) u_dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus0)
    );

    i_fetch #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .RESET_PC(16'hFFFE)) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus1)
    );

    // Behavioural 1-cycle-latency RAMs
    always @(posedge clk) if (bus0.imem_en) bus0.imem_data <= bus0.imem_addr ^ 16'hA5A5;
    always @(posedge clk) if (bus1.imem_en) bus1.imem_data <= bus1.imem_addr ^ 16'hA5A5;
    assign bus0.instr_ready = ready;
    assign bus1.instr_ready = ready;

    logic        v_valid [2];
    logic        v_en    [2];
    logic [15:0] v_addr  [2];
    logic [15:0] v_instr [2];
    logic [15:0] v_ipc   [2];

    assign v_valid[0] = bus0.instr_valid;
    assign v_en[0]    = bus0.imem_en;
    assign v_addr[0]  = bus0.imem_addr;
    assign v_instr[0] = bus0.instr;
    assign v_ipc[0]   = bus0.instr_pc;
    assign v_valid[1] = bus1.instr_valid;
    assign v_en[1]    = bus1.imem_en;
    assign v_addr[1]  = bus1.imem_addr;
    assign v_instr[1] = bus1.instr;
    assign v_ipc[1]   = bus1.instr_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of visible words plus one in-flight read, checked every cycle.
    for (genvar d = 0; d < 2; d++) begin : g_model
        localparam logic [15:0] MODEL_RESET_PC = (d == 0) ? 16'h0000 : 16'hFFFE;
        logic [15:0] vis_q [$];
        logic        infl;
        logic [15:0] infl_pc;
        logic [15:0] mpc;
        logic        exp_valid;
        logic        exp_en;
        logic        mpop;
        int          occ;

        initial begin
            infl    = 1'b0;
            infl_pc = 16'h0000;
            mpc     = MODEL_RESET_PC;
        end

        always @(negedge clk) begin
            if (!rst_n) begin
                vis_q.delete();
                infl = 1'b0;
                mpc  = MODEL_RESET_PC;
                check($sformatf("m%0d_rst_valid", d), 32'(v_valid[d]), 32'd0);
                check($sformatf("m%0d_rst_en", d), 32'(v_en[d]), 32'd0);
                check($sformatf("m%0d_rst_instr", d), 32'(v_instr[d]), 32'd0);
                check($sformatf("m%0d_rst_ipc", d), 32'(v_ipc[d]), 32'd0);
            end else begin
                exp_valid = (vis_q.size() != 0);
                mpop      = exp_valid && ready && !redirect;
                occ       = vis_q.size() + (infl ? 1 : 0) - (mpop ? 1 : 0);
                exp_en    = redirect || (fetch_en && occ < 2);
                check($sformatf("m%0d_valid", d), 32'(v_valid[d]), 32'(exp_valid));
                check($sformatf("m%0d_en", d), 32'(v_en[d]), 32'(exp_en));
                if (exp_en) begin
                    check($sformatf("m%0d_addr", d), 32'(v_addr[d]),
                          32'(redirect ? redirect_pc : mpc));
                end
                if (exp_valid) begin
                    check($sformatf("m%0d_ipc", d), 32'(v_ipc[d]), 32'(vis_q[0]));
                    check($sformatf("m%0d_instr", d), 32'(v_instr[d]),
                          32'(vis_q[0] ^ 16'hA5A5));
                end
                if (redirect) begin
                    vis_q.delete();
                    infl    = 1'b1;
                    infl_pc = redirect_pc;
                    mpc     = redirect_pc + 16'd1;
                end else begin
                    if (mpop) void'(vis_q.pop_front());
                    if (infl) vis_q.push_back(infl_pc);
                    infl = exp_en;
                    if (exp_en) begin
                        infl_pc = mpc;
                        mpc     = mpc + 16'd1;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic head0(input string name, input logic [15:0] pc, input logic [15:0] ins);
        check({name, "_valid"}, 32'(bus0.instr_valid), 32'd1);
        check({name, "_pc"}, 32'(bus0.instr_pc), 32'(pc));
        check({name, "_instr"}, 32'(bus0.instr), 32'(ins));
    endtask

    logic [31:0] pat;

    initial begin
        #2 rst_n = 1'b0;
        step();
        step();
        @(negedge clk);
        check("rst_valid0", 32'(bus0.instr_valid), 32'd0);
        check("rst_en0", 32'(bus0.imem_en), 32'd0);

        // Test 1: streaming from reset
        step();
        rst_n = 1'b1; fetch_en = 1'b1; ready = 1'b1;
        @(negedge clk);
        check("t1_en_c0", 32'(bus0.imem_en), 32'd1);
        check("t1_addr_c0", 32'(bus0.imem_addr), 32'h0000);
        check("t1_valid_c0", 32'(bus0.instr_valid), 32'd0);
        step(); @(negedge clk);
        check("t1_addr_c1", 32'(bus0.imem_addr), 32'h0001);
        check("t1_valid_c1", 32'(bus0.instr_valid), 32'd0);
        step(); @(negedge clk);
        head0("t1_c2", 16'h0000, 16'hA5A5);
        check("t4_pc_c2", 32'(bus1.instr_pc), 32'hFFFE);
        check("t4_instr_c2", 32'(bus1.instr), 32'h5A5B);
        step(); @(negedge clk);
        head0("t1_c3", 16'h0001, 16'hA5A4);
        check("t4_pc_c3", 32'(bus1.instr_pc), 32'hFFFF);
        check("t4_instr_c3", 32'(bus1.instr), 32'h5A5A);
        step(); @(negedge clk);
        head0("t1_c4", 16'h0002, 16'hA5A7);
        check("t4_pc_c4", 32'(bus1.instr_pc), 32'h0000);
        check("t4_instr_c4", 32'(bus1.instr), 32'hA5A5);

        // Test 2: five-cycle decode stall
        step();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            head0($sformatf("t2_stall%0d", i), 16'h0003, 16'h0003 ^ 16'hA5A5);
            check($sformatf("t2_en%0d", i), 32'(bus0.imem_en), 32'd0);
            check($sformatf("t2_addr%0d", i), 32'(bus0.imem_addr), 32'h0005);
            if (i < 4) step();
        end
        step();
        ready = 1'b1;
        @(negedge clk);
        head0("t2_r0", 16'h0003, 16'h0003 ^ 16'hA5A5);
        check("t2_resume_en", 32'(bus0.imem_en), 32'd1);
        check("t2_resume_addr", 32'(bus0.imem_addr), 32'h0005);
        step(); @(negedge clk);
        head0("t2_r1", 16'h0004, 16'h0004 ^ 16'hA5A5);
        step(); @(negedge clk);
        head0("t2_r2", 16'h0005, 16'h0005 ^ 16'hA5A5);

        // Test 3: redirect while the buffer is full
        step(); ready = 1'b0;
        step();
        step();
        step();
        redirect = 1'b1; redirect_pc = 16'h0100; ready = 1'b1;
        @(negedge clk);
        check("t3_rd_en", 32'(bus0.imem_en), 32'd1);
        check("t3_rd_addr", 32'(bus0.imem_addr), 32'h0100);
        check("t3_rd_valid", 32'(bus0.instr_valid), 32'd1);
        step();
        redirect = 1'b0;
        @(negedge clk);
        check("t3_n1_valid", 32'(bus0.instr_valid), 32'd0);
        step(); @(negedge clk);
        head0("t3_n2", 16'h0100, 16'hA4A5);
        step(); @(negedge clk);
        head0("t3_n3", 16'h0101, 16'hA4A4);

        // Test 5: fetch_en drops with one read in flight
        step();
        fetch_en = 1'b0;
        @(negedge clk);
        head0("t5_a", 16'h0102, 16'h0102 ^ 16'hA5A5);
        check("t5_a_en", 32'(bus0.imem_en), 32'd0);
        step(); @(negedge clk);
        head0("t5_b", 16'h0103, 16'h0103 ^ 16'hA5A5);
        check("t5_b_en", 32'(bus0.imem_en), 32'd0);
        step(); @(negedge clk);
        check("t5_c_valid", 32'(bus0.instr_valid), 32'd0);
        check("t5_c_en", 32'(bus0.imem_en), 32'd0);
        step();
        fetch_en = 1'b1;
        @(negedge clk);
        check("t5_resume_en", 32'(bus0.imem_en), 32'd1);
        check("t5_resume_addr", 32'(bus0.imem_addr), 32'h0104);
        repeat (4) step();

        // Test 6: one-cycle reset mid-stream
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_valid", 32'(bus0.instr_valid), 32'd0);
        check("t6_en", 32'(bus0.imem_en), 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_rel_en", 32'(bus0.imem_en), 32'd1);
        check("t6_rel_addr", 32'(bus0.imem_addr), 32'h0000);
        check("t6_rel_valid", 32'(bus0.instr_valid), 32'd0);
        step();
        step(); @(negedge clk);
        head0("t6_first", 16'h0000, 16'hA5A5);
        check("t6_first_pc1", 32'(bus1.instr_pc), 32'hFFFE);

        // Mixed backpressure, fetch gating and a redirect to the top of memory
        pat = 32'hB3C6_5A1D;
        for (int i = 0; i < 32; i++) begin
            step();
            ready       = pat[i];
            fetch_en    = (i % 7) != 3;
            redirect    = (i == 20);
            redirect_pc = 16'hFFFF;
        end
        step();
        redirect = 1'b0;
        repeat (6) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
